// File: rtl/control_unit_pkg.sv
// Shared definitions for the 8-bit processor control unit: opcodes, ALU codes,
// sequencer state encodings and the decoded-instruction struct.
package control_unit_pkg;

  // Instruction opcodes (ir[15:12])
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_INV  = 4'b0101;
  localparam logic [3:0] OP_LOAD = 4'b1000;
  localparam logic [3:0] OP_INC  = 4'b1010;
  localparam logic [3:0] OP_DEC  = 4'b1011;
  localparam logic [3:0] OP_HLT  = 4'b1100;
  localparam logic [3:0] OP_JNZ  = 4'b1110;
  localparam logic [3:0] OP_JMP  = 4'b1111;

  // ALU operation codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_INV = 3'b101;

  // Sequencer states
  localparam logic [3:0] ST_FETCH  = 4'd0;
  localparam logic [3:0] ST_DECODE = 4'd1;
  localparam logic [3:0] ST_RDA    = 4'd2;
  localparam logic [3:0] ST_RDB    = 4'd3;
  localparam logic [3:0] ST_EXEC   = 4'd4;
  localparam logic [3:0] ST_WB     = 4'd5;
  localparam logic [3:0] ST_WF     = 4'd6;
  localparam logic [3:0] ST_JCHK   = 4'd7;
  localparam logic [3:0] ST_HALT   = 4'd8;

  localparam logic [2:0] FLAG_ADDR_DEFAULT = 3'd7;

  typedef struct packed {
    logic       is_alu;    // writes result and flags
    logic       needs_b;   // second operand read from srcB
    logic       b_is_one;  // INC/DEC: operand A is dst, B is constant 1
    logic       is_load;
    logic       is_jmp;
    logic       is_jnz;
    logic       is_hlt;
    logic [2:0] alu_op;
  } dec_t;

  // Flags byte layout stored at FLAG_ADDR
  function automatic logic [7:0] flags_byte(input logic cy, input logic zero);
    return {cy, zero, 6'b000000};
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Combinational instruction classifier: opcode nibble -> control flags.
module cu_decode
  import control_unit_pkg::*;
(
  input  logic [3:0] op,
  output dec_t       dec
);

  // Classify opcode; undefined opcodes leave every flag low (NOP)
  always_comb begin
    dec = '0;
    case (op)
      OP_ADD:  begin dec.is_alu = 1'b1; dec.needs_b = 1'b1; dec.alu_op = ALU_ADD; end
      OP_SUB:  begin dec.is_alu = 1'b1; dec.needs_b = 1'b1; dec.alu_op = ALU_SUB; end
      OP_AND:  begin dec.is_alu = 1'b1; dec.needs_b = 1'b1; dec.alu_op = ALU_AND; end
      OP_OR:   begin dec.is_alu = 1'b1; dec.needs_b = 1'b1; dec.alu_op = ALU_OR;  end
      OP_XOR:  begin dec.is_alu = 1'b1; dec.needs_b = 1'b1; dec.alu_op = ALU_XOR; end
      OP_INV:  begin dec.is_alu = 1'b1; dec.alu_op = ALU_INV; end
      OP_INC:  begin dec.is_alu = 1'b1; dec.b_is_one = 1'b1; dec.alu_op = ALU_ADD; end
      OP_DEC:  begin dec.is_alu = 1'b1; dec.b_is_one = 1'b1; dec.alu_op = ALU_SUB; end
      OP_LOAD: dec.is_load = 1'b1;
      OP_JMP:  dec.is_jmp  = 1'b1;
      OP_JNZ:  dec.is_jnz  = 1'b1;
      OP_HLT:  dec.is_hlt  = 1'b1;
      default: dec = '0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit processor.
// Strobe semantics: ir_en, reg_rd and reg_wr are pure decodes of the state
// register; each is a level for exactly the cycle(s) the FSM sits in the
// owning state, with no handshake back from the datapath (register file and
// ALU answer combinationally in the same cycle).
module control_unit
  import control_unit_pkg::*;
#(
  parameter logic [7:0] PC_RESET  = 8'h00,
  parameter logic [2:0] FLAG_ADDR = FLAG_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [7:0]  pc,
  output logic        ir_en,
  input  logic [15:0] ir_data,
  output logic [2:0]  reg_addr,
  output logic        reg_rd,
  output logic        reg_wr,
  output logic [7:0]  reg_data_in,
  input  logic [7:0]  reg_data_out,
  output logic [2:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_out,
  input  logic        cy,
  input  logic        zero,
  output logic        halted,
  output logic [3:0]  dbg_state
);

  logic [3:0]  state;
  logic [15:0] ir_q;
  logic [7:0]  res_q;
  logic        cy_q;
  logic        z_q;
  dec_t        dec;

  logic [2:0]  dst;
  logic [2:0]  src_a;
  logic [2:0]  src_b;
  logic [7:0]  imm;
  logic [7:0]  pc_inc;
  logic        unused_ir_bits;

  assign dst    = {1'b0, ir_q[9:8]};
  assign src_a  = {1'b0, ir_q[5:4]};
  assign src_b  = {1'b0, ir_q[1:0]};
  assign imm    = ir_q[7:0];
  assign pc_inc = pc + 8'd1;  // wraps mod 256
  assign unused_ir_bits = ^ir_q[11:10];

  cu_decode u_decode (
    .op  (ir_q[15:12]),
    .dec (dec)
  );

  // Sequencer state, program counter and datapath holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_FETCH;
      pc    <= PC_RESET;
      ir_q  <= '0;
      alu_a <= '0;
      alu_b <= '0;
      res_q <= '0;
      cy_q  <= 1'b0;
      z_q   <= 1'b0;
    end else begin
      case (state)
        ST_FETCH: begin
          ir_q  <= ir_data;
          state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (dec.is_hlt) begin
            state <= ST_HALT;
          end else if (dec.is_jmp) begin
            pc    <= imm;
            state <= ST_FETCH;
          end else if (dec.is_load) begin
            state <= ST_WB;
          end else if (dec.is_alu || dec.is_jnz) begin
            state <= ST_RDA;
          end else begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end
        end
        ST_RDA: begin
          alu_a <= reg_data_out;
          if (dec.is_jnz) begin
            state <= ST_JCHK;
          end else if (dec.needs_b) begin
            state <= ST_RDB;
          end else begin
            alu_b <= dec.b_is_one ? 8'h01 : 8'h00;
            state <= ST_EXEC;
          end
        end
        ST_RDB: begin
          alu_b <= reg_data_out;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          res_q <= alu_out;
          cy_q  <= cy;
          z_q   <= zero;
          state <= ST_WB;
        end
        ST_WB: begin
          if (dec.is_load) begin
            pc    <= pc_inc;
            state <= ST_FETCH;
          end else begin
            state <= ST_WF;
          end
        end
        ST_WF: begin
          pc    <= pc_inc;
          state <= ST_FETCH;
        end
        ST_JCHK: begin
          pc    <= (alu_a != 8'h00) ? imm : pc_inc;
          state <= ST_FETCH;
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_FETCH;
      endcase
    end
  end

  // Strobes and register-file addressing decoded from the current state
  always_comb begin
    ir_en       = 1'b0;
    reg_rd      = 1'b0;
    reg_wr      = 1'b0;
    reg_addr    = 3'd0;
    reg_data_in = 8'h00;
    alu_opcode  = 3'b000;
    case (state)
      ST_FETCH: ir_en = 1'b1;
      ST_RDA: begin
        reg_rd   = 1'b1;
        reg_addr = (dec.b_is_one || dec.is_jnz) ? dst : src_a;
      end
      ST_RDB: begin
        reg_rd   = 1'b1;
        reg_addr = src_b;
      end
      ST_EXEC: alu_opcode = dec.alu_op;
      ST_WB: begin
        reg_wr      = 1'b1;
        reg_addr    = dst;
        reg_data_in = dec.is_load ? imm : res_q;
      end
      ST_WF: begin
        reg_wr      = 1'b1;
        reg_addr    = FLAG_ADDR;
        reg_data_in = flags_byte(cy_q, z_q);
      end
      default: ;
    endcase
  end

  assign halted    = (state == ST_HALT);
  assign dbg_state = state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with behavioural instruction memory,
// register file and ALU around it.
module tb_control_unit;
  import control_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pc;
  logic        ir_en;
  logic [15:0] ir_data;
  logic [2:0]  reg_addr;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_data_in;
  logic [7:0]  reg_data_out;
  logic [2:0]  alu_opcode;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [7:0]  alu_out;
  logic        cy;
  logic        zero;
  logic        halted;
  logic [3:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  logic [15:0] imem [256];
  logic [7:0]  regs [8];
  logic [10:0] exp_q  [$];
  logic [10:0] wr_log [$];

  control_unit #(.PC_RESET(8'h00), .FLAG_ADDR(3'd7)) dut (
    .clk          (clk),
    .rst          (rst),
    .pc           (pc),
    .ir_en        (ir_en),
    .ir_data      (ir_data),
    .reg_addr     (reg_addr),
    .reg_rd       (reg_rd),
    .reg_wr       (reg_wr),
    .reg_data_in  (reg_data_in),
    .reg_data_out (reg_data_out),
    .alu_opcode   (alu_opcode),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_out      (alu_out),
    .cy           (cy),
    .zero         (zero),
    .halted       (halted),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- datapath models ----------------
  assign ir_data      = imem[pc];
  assign reg_data_out = regs[reg_addr];

  always_comb begin
    logic [8:0] sum;
    sum     = 9'd0;
    alu_out = 8'h00;
    cy      = 1'b0;
    case (alu_opcode)
      ALU_ADD: begin sum = {1'b0, alu_a} + {1'b0, alu_b}; alu_out = sum[7:0]; cy = sum[8]; end
      ALU_SUB: begin alu_out = alu_a - alu_b; cy = (alu_a < alu_b); end
      ALU_AND: alu_out = alu_a & alu_b;
      ALU_OR:  alu_out = alu_a | alu_b;
      ALU_XOR: alu_out = alu_a ^ alu_b;
      ALU_INV: alu_out = ~alu_a;
      default: alu_out = 8'h00;
    endcase
    zero = (alu_out == 8'h00);
  end

  always @(posedge clk) begin
    if (reg_wr) begin
      regs[reg_addr] <= reg_data_in;
      wr_log.push_back({reg_addr, reg_data_in});
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [1:0] d,
                                        input logic [1:0] a, input logic [1:0] b);
    return {op, 2'b00, d, 2'b00, a, 2'b00, b};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [1:0] d,
                                        input logic [7:0] imm);
    return {op, 2'b00, d, imm};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_env();
    for (int i = 0; i < 256; i++) imem[i] = 16'hC000;  // HLT fill
    for (int i = 0; i < 8; i++) regs[i] = 8'hAA;
    wr_log.delete();
    exp_q.delete();
  endtask

  // Leaves rst asserted after two edges; caller releases it
  task automatic hold_reset();
    rst = 1'b1;
    tick();
    tick();
  endtask

  // Advance from FETCH until the FSM returns to FETCH; returns cycle count
  task automatic step(output int cyc);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (dbg_state != ST_FETCH && cyc < 40);
  endtask

  task automatic compare_writes(input string tag);
    check({tag, "_wr_count"}, wr_log.size(), exp_q.size());
    while (exp_q.size() > 0 && wr_log.size() > 0)
      check({tag, "_wr"}, wr_log.pop_front(), exp_q.pop_front());
  endtask

  // ---------------- tests ----------------
  initial begin
    int cyc;
    int n;
    int execs;
    logic ok;
    logic [7:0] pc_hold;

    // Test 1: reset state, LOAD/LOAD/ADD timing and results
    clear_env();
    imem[0] = enc_i(OP_LOAD, 2'd0, 8'h05);
    imem[1] = enc_i(OP_LOAD, 2'd1, 8'h03);
    imem[2] = enc_r(OP_ADD, 2'd2, 2'd0, 2'd1);
    hold_reset();
    check("rst_state", dbg_state, ST_FETCH);
    check("rst_pc", pc, 8'h00);
    check("rst_ir_en", ir_en, 1'b1);
    check("rst_strobes", {reg_rd, reg_wr, halted}, 3'b000);
    check("rst_addr_data", {reg_addr, reg_data_in}, 11'h0);
    check("rst_alu", {alu_opcode, alu_a, alu_b}, 19'h0);
    rst = 1'b0;
    wr_log.delete();
    step(cyc);
    check("load0_cycles", cyc, 3);
    check("load0_pc", pc, 8'h01);
    step(cyc);
    check("load1_cycles", cyc, 3);
    check("load1_pc", pc, 8'h02);
    check("load_flags_untouched", regs[7], 8'hAA);
    step(cyc);
    check("add_cycles", cyc, 7);
    check("add_pc", pc, 8'h03);
    check("add_r2", regs[2], 8'h08);
    check("add_flags", regs[7], 8'h00);
    exp_q.push_back({3'd0, 8'h05});
    exp_q.push_back({3'd1, 8'h03});
    exp_q.push_back({3'd2, 8'h08});
    exp_q.push_back({3'd7, 8'h00});
    compare_writes("t1");

    // Test 2: SUB to zero, INC wrap with carry, INV, OR
    clear_env();
    imem[0] = enc_i(OP_LOAD, 2'd0, 8'h03);
    imem[1] = enc_r(OP_SUB, 2'd1, 2'd0, 2'd0);
    imem[2] = enc_i(OP_LOAD, 2'd0, 8'hFF);
    imem[3] = enc_i(OP_INC, 2'd0, 8'h00);
    imem[4] = enc_i(OP_LOAD, 2'd2, 8'h0F);
    imem[5] = enc_r(OP_INV, 2'd3, 2'd2, 2'd0);
    imem[6] = enc_r(OP_OR, 2'd1, 2'd2, 2'd3);
    hold_reset();
    rst = 1'b0;
    step(cyc);
    step(cyc);
    check("sub_cycles", cyc, 7);
    check("sub_r1", regs[1], 8'h00);
    check("sub_flags", regs[7], 8'h40);
    step(cyc);
    step(cyc);
    check("inc_cycles", cyc, 6);
    check("inc_r0", regs[0], 8'h00);
    check("inc_flags", regs[7], 8'hC0);
    step(cyc);
    step(cyc);
    check("inv_cycles", cyc, 6);
    check("inv_r3", regs[3], 8'hF0);
    check("inv_flags", regs[7], 8'h00);
    step(cyc);
    check("or_r1", regs[1], 8'hFF);
    check("or_pc", pc, 8'h07);

    // Test 3: DEC/JNZ loop, then halt behaviour and recovery
    clear_env();
    imem[0] = enc_i(OP_LOAD, 2'd0, 8'h03);
    imem[1] = enc_i(OP_DEC, 2'd0, 8'h00);
    imem[2] = enc_i(OP_JNZ, 2'd0, 8'h01);
    imem[3] = enc_i(OP_HLT, 2'd0, 8'h00);
    hold_reset();
    rst = 1'b0;
    execs = 0;
    n = 0;
    while (!halted && n < 300) begin
      tick();
      n++;
      if (dbg_state == ST_EXEC) execs++;
    end
    check("loop_halted", halted, 1'b1);
    check("loop_dec_count", execs, 3);
    check("loop_r0", regs[0], 8'h00);
    check("loop_flags", regs[7], 8'h40);
    check("loop_pc", pc, 8'h03);
    ok = 1'b1;
    pc_hold = pc;
    wr_log.delete();
    repeat (20) begin
      tick();
      if (ir_en || reg_rd || reg_wr || !halted || pc != pc_hold) ok = 1'b0;
    end
    check("halt_idle_quiet", ok, 1'b1);
    check("halt_idle_no_writes", wr_log.size(), 0);
    hold_reset();
    check("halt_rst_halted", halted, 1'b0);
    check("halt_rst_pc", pc, 8'h00);
    rst = 1'b0;
    check("halt_rst_fetch", {dbg_state, ir_en}, {ST_FETCH, 1'b1});

    // Test 4: JMP near top of memory, NOPs wrap pc to 0
    clear_env();
    imem[0]     = enc_i(OP_JMP, 2'd0, 8'hFE);
    imem[8'hFE] = 16'h6000;
    imem[8'hFF] = 16'h6000;
    hold_reset();
    rst = 1'b0;
    wr_log.delete();
    step(cyc);
    check("jmp_cycles", cyc, 2);
    check("jmp_pc", pc, 8'hFE);
    step(cyc);
    check("nop_cycles", cyc, 2);
    check("nop_pc", pc, 8'hFF);
    step(cyc);
    check("wrap_pc", pc, 8'h00);
    check("jmp_nop_no_writes", wr_log.size(), 0);

    // Test 5: reset taken at the edge that would enter WB of ADD
    clear_env();
    imem[0] = enc_i(OP_LOAD, 2'd0, 8'h05);
    imem[1] = enc_i(OP_LOAD, 2'd1, 8'h03);
    imem[2] = enc_r(OP_ADD, 2'd2, 2'd0, 2'd1);
    hold_reset();
    rst = 1'b0;
    step(cyc);
    step(cyc);
    n = 0;
    while (dbg_state != ST_EXEC && n < 20) begin
      tick();
      n++;
    end
    check("abort_reached_exec", dbg_state, ST_EXEC);
    rst = 1'b1;
    tick();
    check("abort_reg_wr", reg_wr, 1'b0);
    check("abort_pc", pc, 8'h00);
    check("abort_state", dbg_state, ST_FETCH);
    rst = 1'b0;
    tick();
    check("abort_dst_unchanged", regs[2], 8'hAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
